// File: rtl/k_and_s_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : k_and_s_pkg                                                   |
// | Purpose  : Shared types for the K&S RAM port arbiter: arbiter FSM state,  |
// |            requester identity and the largest supported read latency.   |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package k_and_s_pkg;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_RD_WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_L = 1'b1
  } arb_port_t;

  localparam int RD_LAT_MAX = 4;

endpackage
`default_nettype wire

// File: rtl/arb_rr_picker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : arb_rr_picker                                                 |
// | Purpose  : Combinational winner select between the core (C) and the      |
// |            loader (L). A tie goes to C under fixed priority, otherwise   |
// |            to the port that did not win last time.                       |
// | Ports    : ec          in  effective core request (already halt-masked)  |
// |            ldr_req     in  loader request                                |
// |            last_winner in  port granted most recently                    |
// |            valid       out at least one request present                  |
// |            winner      out selected port (meaningful when valid)         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module arb_rr_picker
  import k_and_s_pkg::*;
#(
  parameter int CORE_PRIO = 0
) (
  input  logic      ec,
  input  logic      ldr_req,
  input  arb_port_t last_winner,
  output logic      valid,
  output arb_port_t winner
);

  always_comb begin
    valid  = ec | ldr_req;
    winner = PORT_C;
    if (ec && ldr_req) begin
      // Round-robin tie: hand the RAM to whoever did not have it last.
      if ((CORE_PRIO == 0) && (last_winner == PORT_C)) begin
        winner = PORT_L;
      end
    end else if (ldr_req) begin
      winner = PORT_L;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ram_port_arbiter                                              |
// | Purpose  : Shares the single-port K&S RAM between the core (port C) and  |
// |            the loader/debug port (port L). Writes complete in the grant  |
// |            cycle; reads hold the RAM for RD_LAT cycles and return data   |
// |            with a one-cycle rvalid pulse.                                |
// | Ports    : clk, rst_n (sync, active-low)                                 |
// |            core_halt                     masks core_req while high       |
// |            core_req/we/addr/wdata  in    port C request                  |
// |            core_gnt/rvalid/rdata   out   port C response                 |
// |            ldr_*                         same set for port L             |
// |            ram_addr/wdata/write_enable out, ram_rdata in : RAM macro     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ram_port_arbiter
  import k_and_s_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int CORE_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_halt,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_write_enable,
  input  logic [DATA_W-1:0] ram_rdata
);

  // Counter load value: rvalid fires once the counter has run down to zero.
  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  arb_state_t        state_q, state_d;
  logic [1:0]        lat_cnt_q, lat_cnt_d;
  arb_port_t         last_winner_q, last_winner_d;
  arb_port_t         owner_q, owner_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;

  logic              ec;
  logic              pick_valid;
  arb_port_t         pick_winner;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  assign ec = core_req & ~core_halt;

  arb_rr_picker #(
    .CORE_PRIO (CORE_PRIO)
  ) u_picker (
    .ec          (ec),
    .ldr_req     (ldr_req),
    .last_winner (last_winner_q),
    .valid       (pick_valid),
    .winner      (pick_winner)
  );

  always_comb begin
    win_we    = (pick_winner == PORT_L) ? ldr_we    : core_we;
    win_addr  = (pick_winner == PORT_L) ? ldr_addr  : core_addr;
    win_wdata = (pick_winner == PORT_L) ? ldr_wdata : core_wdata;
  end

  always_comb begin
    state_d          = state_q;
    lat_cnt_d        = lat_cnt_q;
    last_winner_d    = last_winner_q;
    owner_d          = owner_q;
    rd_addr_d        = rd_addr_q;
    core_rdata_d     = core_rdata_q;
    ldr_rdata_d      = ldr_rdata_q;
    core_gnt         = 1'b0;
    ldr_gnt          = 1'b0;
    core_rvalid      = 1'b0;
    ldr_rvalid       = 1'b0;
    core_rdata       = core_rdata_q;
    ldr_rdata        = ldr_rdata_q;
    ram_addr         = '0;
    ram_wdata        = '0;
    ram_write_enable = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          core_gnt      = (pick_winner == PORT_C);
          ldr_gnt       = (pick_winner == PORT_L);
          ram_addr      = win_addr;
          last_winner_d = pick_winner;
          if (win_we) begin
            ram_wdata        = win_wdata;
            ram_write_enable = 1'b1;
          end else begin
            owner_d   = pick_winner;
            rd_addr_d = win_addr;
            lat_cnt_d = LAT_INIT;
            state_d   = ARB_RD_WAIT;
          end
        end
      end
      ARB_RD_WAIT: begin
        // Keep the address stable for the whole synchronous read.
        ram_addr = rd_addr_q;
        if (lat_cnt_q != 2'd0) begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end else begin
          // Data is forwarded in the rvalid cycle and captured for holding.
          if (owner_q == PORT_L) begin
            ldr_rvalid  = 1'b1;
            ldr_rdata   = ram_rdata;
            ldr_rdata_d = ram_rdata;
          end else begin
            core_rvalid  = 1'b1;
            core_rdata   = ram_rdata;
            core_rdata_d = ram_rdata;
          end
          state_d = ARB_IDLE;
        end
      end
    endcase

    // While reset is asserted nothing may reach the RAM or the requesters;
    // an in-flight read is dropped silently.
    if (!rst_n) begin
      core_gnt         = 1'b0;
      ldr_gnt          = 1'b0;
      core_rvalid      = 1'b0;
      ldr_rvalid       = 1'b0;
      core_rdata       = core_rdata_q;
      ldr_rdata        = ldr_rdata_q;
      ram_addr         = '0;
      ram_wdata        = '0;
      ram_write_enable = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ARB_IDLE;
      lat_cnt_q     <= 2'd0;
      last_winner_q <= PORT_L;
      owner_q       <= PORT_C;
      rd_addr_q     <= '0;
      core_rdata_q  <= '0;
      ldr_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      lat_cnt_q     <= lat_cnt_d;
      last_winner_q <= last_winner_d;
      owner_q       <= owner_d;
      rd_addr_q     <= rd_addr_d;
      core_rdata_q  <= core_rdata_d;
      ldr_rdata_q   <= ldr_rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ram_port_arbiter                                           |
// | Purpose  : Self-checking bench. Two arbiters (RD_LAT=1 round-robin and   |
// |            RD_LAT=3 core-priority) share one stimulus stream; each owns  |
// |            a behavioural RAM and is compared every cycle against a       |
// |            transaction-level reference model.                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_halt, core_req, core_we, ldr_req, ldr_we;
  logic [7:0]  core_addr, ldr_addr;
  logic [15:0] core_wdata, ldr_wdata;

  logic [1:0]  core_gnt_o, core_rvalid_o, ldr_gnt_o, ldr_rvalid_o, ram_we_o;
  logic [15:0] core_rdata_o [2];
  logic [15:0] ldr_rdata_o  [2];
  logic [7:0]  ram_addr_o   [2];
  logic [15:0] ram_wdata_o  [2];
  logic [15:0] ram_rdata_i  [2];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_init(input int a);
    return 16'((a * 16'h0101) ^ 16'h5A00);
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : 3;
    localparam int PRI = (gi == 0) ? 0 : 1;
    logic [15:0] mem  [256];
    logic [7:0]  pipe [4];

    ram_port_arbiter #(
      .ADDR_W(8), .DATA_W(16), .RD_LAT(LAT), .CORE_PRIO(PRI)
    ) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .core_halt        (core_halt),
      .core_req         (core_req),
      .core_we          (core_we),
      .core_addr        (core_addr),
      .core_wdata       (core_wdata),
      .core_gnt         (core_gnt_o[gi]),
      .core_rvalid      (core_rvalid_o[gi]),
      .core_rdata       (core_rdata_o[gi]),
      .ldr_req          (ldr_req),
      .ldr_we           (ldr_we),
      .ldr_addr         (ldr_addr),
      .ldr_wdata        (ldr_wdata),
      .ldr_gnt          (ldr_gnt_o[gi]),
      .ldr_rvalid       (ldr_rvalid_o[gi]),
      .ldr_rdata        (ldr_rdata_o[gi]),
      .ram_addr         (ram_addr_o[gi]),
      .ram_wdata        (ram_wdata_o[gi]),
      .ram_write_enable (ram_we_o[gi]),
      .ram_rdata        (ram_rdata_i[gi])
    );

    // Synchronous RAM: data for an address appears LAT cycles later.
    assign ram_rdata_i[gi] = mem[pipe[LAT-1]];

    initial begin
      for (int a = 0; a < 256; a++) mem[a] = mem_init(a);
      for (int s = 0; s < 4; s++) pipe[s] = 8'h00;
    end

    always @(posedge clk) begin
      if (ram_we_o[gi]) mem[ram_addr_o[gi]] <= ram_wdata_o[gi];
      pipe[0] <= ram_addr_o[gi];
      for (int s = 1; s < 4; s++) pipe[s] <= pipe[s-1];
    end
  end

  // ---------------- reference model (transaction level) ----------------
  int          m_lat [2] = '{1, 3};
  int          m_pri [2] = '{0, 1};
  logic [15:0] shadow [2][256];
  logic        m_busy [2];
  int          m_done [2];
  logic        m_owner_l [2];
  logic [7:0]  m_raddr [2];
  logic        m_last_l [2];
  logic [15:0] m_held_c [2];
  logic [15:0] m_held_l [2];

  task automatic chk(input string tag, input int k, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s[%0d] cyc=%0d: observed %h expected %h", tag, k, cyc, got, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_busy[k]   = 1'b0;
    m_last_l[k] = 1'b1;
    m_held_c[k] = 16'h0;
    m_held_l[k] = 16'h0;
  endtask

  task automatic model_check(input int k);
    logic        ec, win_l, wwe;
    logic [7:0]  wa;
    logic [15:0] wd;
    logic        e_cg, e_lg, e_cv, e_lv, e_we;
    logic [7:0]  e_a;
    logic [15:0] e_wd;
    e_cg = 0; e_lg = 0; e_cv = 0; e_lv = 0; e_we = 0; e_a = 0; e_wd = 0;
    if (rst_n) begin
      if (m_busy[k]) begin
        e_a = m_raddr[k];
        if (cyc == m_done[k]) begin
          if (m_owner_l[k]) begin
            e_lv = 1; m_held_l[k] = shadow[k][m_raddr[k]];
          end else begin
            e_cv = 1; m_held_c[k] = shadow[k][m_raddr[k]];
          end
          m_busy[k] = 1'b0;
        end
      end else begin
        ec = core_req && !core_halt;
        if (ec || ldr_req) begin
          if (ec && ldr_req) win_l = (m_pri[k] == 0) && !m_last_l[k];
          else               win_l = ldr_req;
          wwe = win_l ? ldr_we    : core_we;
          wa  = win_l ? ldr_addr  : core_addr;
          wd  = win_l ? ldr_wdata : core_wdata;
          e_lg = win_l; e_cg = !win_l; e_a = wa;
          m_last_l[k] = win_l;
          if (wwe) begin
            e_we = 1; e_wd = wd; shadow[k][wa] = wd;
          end else begin
            m_busy[k] = 1'b1; m_done[k] = cyc + m_lat[k];
            m_owner_l[k] = win_l; m_raddr[k] = wa;
          end
        end
      end
    end
    chk("core_gnt",    k, 32'(core_gnt_o[k]),    32'(e_cg));
    chk("ldr_gnt",     k, 32'(ldr_gnt_o[k]),     32'(e_lg));
    chk("core_rvalid", k, 32'(core_rvalid_o[k]), 32'(e_cv));
    chk("ldr_rvalid",  k, 32'(ldr_rvalid_o[k]),  32'(e_lv));
    chk("core_rdata",  k, 32'(core_rdata_o[k]),  32'(m_held_c[k]));
    chk("ldr_rdata",   k, 32'(ldr_rdata_o[k]),   32'(m_held_l[k]));
    chk("ram_addr",    k, 32'(ram_addr_o[k]),    32'(e_a));
    chk("ram_wdata",   k, 32'(ram_wdata_o[k]),   32'(e_wd));
    chk("ram_we",      k, 32'(ram_we_o[k]),      32'(e_we));
    if (!rst_n) model_reset(k);
  endtask

  task automatic eval();
    @(negedge clk);
    model_check(0);
    model_check(1);
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    eval();
    tick();
  endtask

  task automatic idle_inputs();
    core_halt = 0; core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 256; a++) shadow[k][a] = mem_init(a);
      model_reset(k);
      m_done[k] = 0; m_owner_l[k] = 0; m_raddr[k] = 0;
    end
    idle_inputs();
    rst_n = 1'b0;
    tick();
    step();                      // reset state check
    rst_n = 1'b1;
    step();

    // Core write 0x10 <- 0xBEEF: granted and written in the same cycle.
    core_req = 1; core_we = 1; core_addr = 8'h10; core_wdata = 16'hBEEF;
    eval();
    for (int k = 0; k < 2; k++) begin
      chk("t1_gnt",   k, 32'(core_gnt_o[k]), 32'd1);
      chk("t1_we",    k, 32'(ram_we_o[k]),   32'd1);
      chk("t1_addr",  k, 32'(ram_addr_o[k]), 32'h10);
      chk("t1_wdata", k, 32'(ram_wdata_o[k]), 32'hBEEF);
    end
    tick();

    // Core read 0x10, then loader read waiting behind it.
    core_we = 0;
    step();
    core_req = 0; ldr_req = 1; ldr_we = 0; ldr_addr = 8'h30;
    eval();
    chk("t2_rvalid", 0, 32'(core_rvalid_o[0]), 32'd1);
    chk("t2_rdata",  0, 32'(core_rdata_o[0]),  32'hBEEF);
    chk("t2_nognt",  0, 32'(ldr_gnt_o[0]),     32'd0);
    tick();
    eval();
    chk("t2_ldrgnt", 0, 32'(ldr_gnt_o[0]), 32'd1);
    tick();
    repeat (3) step();
    idle_inputs();
    repeat (6) step();

    // Simultaneous reads held: arbitration order per instance.
    core_req = 1; core_addr = 8'h10; ldr_req = 1; ldr_addr = 8'h05;
    repeat (18) step();
    idle_inputs();
    repeat (6) step();

    // Halted core is ignored; loader write goes through.
    core_halt = 1; core_req = 1; core_addr = 8'h44;
    ldr_req = 1; ldr_we = 1; ldr_addr = 8'h20; ldr_wdata = 16'h1234;
    eval();
    for (int k = 0; k < 2; k++) begin
      chk("t4_lgnt", k, 32'(ldr_gnt_o[k]),  32'd1);
      chk("t4_cgnt", k, 32'(core_gnt_o[k]), 32'd0);
      chk("t4_addr", k, 32'(ram_addr_o[k]), 32'h20);
    end
    tick();
    idle_inputs();
    repeat (2) step();

    // Reset in the middle of a loader read: no rvalid afterwards.
    ldr_req = 1; ldr_we = 0; ldr_addr = 8'h02;
    step();
    idle_inputs();
    rst_n = 0;
    step();
    rst_n = 1;
    repeat (5) step();

    // Back-to-back loader writes 0x00..0x03, then read them back.
    for (int i = 0; i < 4; i++) begin
      ldr_req = 1; ldr_we = 1; ldr_addr = 8'(i); ldr_wdata = 16'(16'hA000 + i);
      step();
    end
    ldr_we = 0;
    for (int i = 0; i < 4; i++) begin
      ldr_addr = 8'(i);
      repeat (4) step();
    end
    idle_inputs();
    repeat (4) step();

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      rst_n      = ($urandom_range(0, 79) != 0);
      core_halt  = ($urandom_range(0, 3) == 0);
      core_req   = 1'($urandom_range(0, 1));
      core_we    = 1'($urandom_range(0, 1));
      core_addr  = 8'($urandom_range(0, 15));
      core_wdata = 16'($urandom);
      ldr_req    = 1'($urandom_range(0, 1));
      ldr_we     = 1'($urandom_range(0, 1));
      ldr_addr   = 8'($urandom_range(0, 15));
      ldr_wdata  = 16'($urandom);
      step();
    end
    rst_n = 1;
    idle_inputs();
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
